// File: rtl/vdg_pkg.sv
// Shared constants and row-geometry lookups for the video address generator.
package vdg_pkg;

  localparam int DA_W       = 13;
  localparam int CHAR_LINES = 12;

  // Graphics mode encodings carried on gm when ag=1
  localparam logic [2:0] GM_CG1 = 3'b000;
  localparam logic [2:0] GM_RG1 = 3'b001;
  localparam logic [2:0] GM_CG2 = 3'b010;
  localparam logic [2:0] GM_RG2 = 3'b011;
  localparam logic [2:0] GM_CG3 = 3'b100;
  localparam logic [2:0] GM_RG3 = 3'b101;
  localparam logic [2:0] GM_CG6 = 3'b110;
  localparam logic [2:0] GM_RG6 = 3'b111;

  // Bytes fetched per display row: 32 for text, 16 or 32 in graphics
  function automatic logic [5:0] bytes_per_row(input logic ag, input logic [2:0] gm);
    logic [5:0] bpr;
    bpr = 6'd32;
    if (ag) begin
      case (gm)
        GM_CG1, GM_RG1, GM_RG2, GM_RG3: bpr = 6'd16;
        default:                        bpr = 6'd32;
      endcase
    end
    return bpr;
  endfunction

  // Scan lines making up one row: a character cell in text, 1..3 in graphics
  function automatic logic [3:0] lines_per_row(input logic ag, input logic [2:0] gm);
    logic [3:0] lpr;
    lpr = 4'(CHAR_LINES);
    if (ag) begin
      case (gm)
        GM_CG1, GM_RG1, GM_CG2: lpr = 4'd3;
        GM_RG2, GM_CG3:         lpr = 4'd2;
        default:                lpr = 4'd1;
      endcase
    end
    return lpr;
  endfunction

endpackage

// File: rtl/video_address_gen_sync_edge.sv
// Registers an active-low sync input once and flags its rising (end-of-sync) edge.
module sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic sync_n,
  output logic rise
);

  logic sync_q;
  logic sync_d;

  // Next register value is simply the sampled input
  always_comb begin
    sync_d = sync_n;
  end

  // Reset loads 1 so an input that is already high after reset is not a rise
  always_ff @(posedge clk) begin
    if (!reset_n) sync_q <= 1'b1;
    else          sync_q <= sync_d;
  end

  // Rise is seen while the input is high and the register still holds the low
  assign rise = ~sync_q & sync_n;

endmodule

// File: rtl/video_address_gen.sv
// Tracks raster position from hsn/fsn, builds the active window, and produces
// byte-fetch strobes, the display RAM address and the row line counter.
// fetch is a one-cycle strobe with no back-pressure: the RAM side latches the
// byte at da in every cycle fetch is high and cannot stall the raster.
module video_address_gen
  import vdg_pkg::*;
#(
  parameter int H_START  = 38,
  parameter int ACTIVE_W = 256,
  parameter int V_START0 = 32,
  parameter int V_START1 = 58,
  parameter int ACTIVE_H = 192
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            hsn,
  input  logic            fsn,
  input  logic            format,
  input  logic            ag,
  input  logic [2:0]      gm,
  output logic [DA_W-1:0] da,
  output logic            fetch,
  output logic [3:0]      row_line,
  output logic            hactive,
  output logic            vactive,
  output logic            de
);

  localparam logic [8:0] CNT_MAX = 9'h1FF;
  localparam logic [8:0] H_LO    = 9'(H_START);
  localparam logic [8:0] H_HI    = 9'(H_START + ACTIVE_W);
  localparam logic [8:0] V_LO0   = 9'(V_START0);
  localparam logic [8:0] V_LO1   = 9'(V_START1);
  localparam logic [8:0] V_SPAN  = 9'(ACTIVE_H);

  logic h_rise, f_rise;

  sync_edge u_hsn_edge (.clk(clk), .reset_n(reset_n), .sync_n(hsn), .rise(h_rise));
  sync_edge u_fsn_edge (.clk(clk), .reset_n(reset_n), .sync_n(fsn), .rise(f_rise));

  logic [8:0]      hc_q, hc_d, vc_q, vc_d;
  logic [7:0]      px_q, px_d;
  logic            hactive_q, hactive_d, vactive_q, vactive_d;
  logic            vstart1_q, vstart1_d;
  logic            ag_q, ag_d;
  logic [2:0]      gm_q, gm_d;
  logic [DA_W-1:0] da_q, da_d, row_start_q, row_start_d;
  logic [3:0]      row_line_q, row_line_d;
  logic [8:0]      v_lo, v_hi;
  logic [5:0]      bpr;
  logic [3:0]      lpr;
  logic            fetch_w;

  // Horizontal counter, saturating so a missing hsn cannot reopen the window
  always_comb begin
    hc_d      = hc_q;
    if (h_rise)              hc_d = '0;
    else if (hc_q != CNT_MAX) hc_d = hc_q + 9'd1;
    hactive_d = (hc_q >= H_LO) && (hc_q < H_HI);
    px_d      = 8'(hc_q - H_LO);
  end

  // Vertical counter, start-line select and per-line mode latch
  always_comb begin
    vc_d      = vc_q;
    vstart1_d = vstart1_q;
    vactive_d = vactive_q;
    ag_d      = ag_q;
    gm_d      = gm_q;
    if (f_rise) begin
      vc_d      = '0;
      vstart1_d = format;
    end else if (h_rise && (vc_q != CNT_MAX)) begin
      vc_d = vc_q + 9'd1;
    end
    v_lo = vstart1_d ? V_LO1 : V_LO0;
    v_hi = v_lo + V_SPAN;
    if (h_rise) begin
      vactive_d = (vc_d >= v_lo) && (vc_d < v_hi);
      ag_d      = ag;
      gm_d      = gm;
    end
  end

  // Fetch on the first active pixel and then every 8 or 16 pixels
  always_comb begin
    bpr     = bytes_per_row(ag_q, gm_q);
    lpr     = lines_per_row(ag_q, gm_q);
    fetch_w = 1'b0;
    if (hactive_q && vactive_q) begin
      if (bpr == 6'd32) fetch_w = (px_q[2:0] == 3'd0);
      else              fetch_w = (px_q[3:0] == 4'd0);
    end
  end

  // Address and row bookkeeping; a frame start overrides everything else
  always_comb begin
    da_d        = da_q;
    row_start_d = row_start_q;
    row_line_d  = row_line_q;
    if (fetch_w) da_d = da_q + 1'b1;
    if (h_rise) begin
      if (!vactive_d) begin
        // Outside the window rows are parked so the first active line starts clean
        row_start_d = '0;
        row_line_d  = '0;
      end else if (vactive_q) begin
        // >= rather than == so a mode change to fewer lines ends the row now
        if (row_line_q >= (lpr - 4'd1)) begin
          row_line_d  = '0;
          row_start_d = row_start_q + {{(DA_W-6){1'b0}}, bpr};
        end else begin
          row_line_d  = row_line_q + 4'd1;
        end
      end
      da_d = row_start_d;
    end
    if (f_rise) begin
      da_d        = '0;
      row_start_d = '0;
      row_line_d  = '0;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hc_q        <= '0;
      vc_q        <= '0;
      px_q        <= '0;
      hactive_q   <= 1'b0;
      vactive_q   <= 1'b0;
      vstart1_q   <= 1'b0;
      ag_q        <= 1'b0;
      gm_q        <= '0;
      da_q        <= '0;
      row_start_q <= '0;
      row_line_q  <= '0;
    end else begin
      hc_q        <= hc_d;
      vc_q        <= vc_d;
      px_q        <= px_d;
      hactive_q   <= hactive_d;
      vactive_q   <= vactive_d;
      vstart1_q   <= vstart1_d;
      ag_q        <= ag_d;
      gm_q        <= gm_d;
      da_q        <= da_d;
      row_start_q <= row_start_d;
      row_line_q  <= row_line_d;
    end
  end

  assign da       = da_q;
  assign fetch    = fetch_w;
  assign row_line = row_line_q;
  assign hactive  = hactive_q;
  assign vactive  = vactive_q;
  assign de       = hactive_q & vactive_q;

endmodule

// File: tb/tb_video_address_gen.sv
// Directed bench for video_address_gen: drives hsn/fsn line by line and
// checks window timing, fetch spacing, addresses and row counting.
module tb_video_address_gen;

  localparam int SHORT   = 6;    // line too short to open the window
  localparam int FULL    = 320;  // line long enough for the whole window
  // Tick 1 is the cycle hc reads 0; hc hits 38 at tick 39, registered window at 40
  localparam int FIRST_T = 40;

  logic        clk = 1'b0;
  logic        reset_n, hsn, fsn, format, ag;
  logic [2:0]  gm;
  logic [12:0] da;
  logic        fetch, hactive, vactive, de;
  logic [3:0]  row_line;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int extra_fetches = 0;

  logic [12:0] exp_q[$];

  int ln_nf, ln_first_t, ln_first_da, ln_last_da, ln_da_end;
  int ln_hact, ln_bad, ln_min_gap, ln_max_gap, ln_rl;
  logic ln_vact;

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  video_address_gen dut (
    .clk(clk), .reset_n(reset_n), .hsn(hsn), .fsn(fsn), .format(format),
    .ag(ag), .gm(gm), .da(da), .fetch(fetch), .row_line(row_line),
    .hactive(hactive), .vactive(vactive), .de(de)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fsync();
    fsn = 1'b0;
    tick();
    tick();
    fsn = 1'b1;
    tick();
  endtask

  // One line: hsn low for 2 clocks, then high for len clocks while recording
  task automatic run_line(input int len, input int chg_at, input logic [2:0] chg_gm);
    int prev_t;
    int gap;
    hsn = 1'b0;
    tick();
    tick();
    hsn = 1'b1;
    ln_nf = 0; ln_first_t = -1; ln_first_da = -1; ln_last_da = -1;
    ln_hact = 0; ln_bad = 0; ln_min_gap = 1 << 20; ln_max_gap = 0; prev_t = 0;
    for (int k = 1; k <= len; k++) begin
      tick();
      if (k == 1) begin
        ln_rl   = int'(row_line);
        ln_vact = vactive;
      end
      if (k == chg_at) gm = chg_gm;
      if (hactive === 1'b1) ln_hact++;
      if (de !== (hactive & vactive)) ln_bad++;
      if (fetch === 1'b1) begin
        if (de !== 1'b1) ln_bad++;
        if (exp_q.size() > 0) chk("fetch_da", 32'(da), 32'(exp_q.pop_front()));
        else extra_fetches++;
        if (ln_nf == 0) begin
          ln_first_t  = k;
          ln_first_da = int'(da);
        end else begin
          gap = k - prev_t;
          if (gap < ln_min_gap) ln_min_gap = gap;
          if (gap > ln_max_gap) ln_max_gap = gap;
        end
        prev_t     = k;
        ln_last_da = int'(da);
        ln_nf++;
      end
    end
    ln_da_end = int'(da);
  endtask

  task automatic short_lines(input int n);
    for (int i = 0; i < n; i++) run_line(SHORT, 0, 3'b000);
  endtask

  // A full active line with its expected fetch addresses queued up front
  task automatic full_line(input string t, input int len, input int chg_at, input logic [2:0] chg_gm,
                           input int exp_da, input int exp_rl, input int exp_nf, input int exp_gap);
    for (int i = 0; i < exp_nf; i++) exp_q.push_back(13'(exp_da + i));
    run_line(len, chg_at, chg_gm);
    chk({t, "_vact"},     32'(ln_vact), 32'd1);
    chk({t, "_row_line"}, ln_rl, exp_rl);
    chk({t, "_nfetch"},   ln_nf, exp_nf);
    chk({t, "_first_t"},  ln_first_t, FIRST_T);
    chk({t, "_first_da"}, ln_first_da, exp_da);
    chk({t, "_last_da"},  ln_last_da, exp_da + exp_nf - 1);
    chk({t, "_da_end"},   ln_da_end, exp_da + exp_nf);
    chk({t, "_gap_min"},  ln_min_gap, exp_gap);
    chk({t, "_gap_max"},  ln_max_gap, exp_gap);
    chk({t, "_hactive"},  ln_hact, 256);
    chk({t, "_de_bad"},   ln_bad, 0);
    chk({t, "_q_left"},   exp_q.size(), 0);
  endtask

  initial begin
    reset_n = 1'b0; hsn = 1'b1; fsn = 1'b1; format = 1'b0; ag = 1'b0; gm = 3'b000;

    // Reset with sync inputs toggling
    for (int i = 0; i < 5; i++) begin
      hsn = i[0];
      fsn = ~i[0];
      tick();
      chk($sformatf("rst%0d_da", i),       32'(da), 0);
      chk($sformatf("rst%0d_fetch", i),    32'(fetch), 0);
      chk($sformatf("rst%0d_de", i),       32'(de), 0);
      chk($sformatf("rst%0d_row_line", i), 32'(row_line), 0);
    end
    hsn = 1'b1; fsn = 1'b1; reset_n = 1'b1;
    tick();
    tick();
    chk("post_rst_de", 32'(de), 0);

    // Alphanumeric frame, format=0
    ag = 1'b0; gm = 3'b000; format = 1'b0;
    fsync();
    short_lines(31);
    chk("a_l31_vact", 32'(ln_vact), 0);
    for (int n = 32; n <= 44; n++)
      full_line($sformatf("a_l%0d", n), (n == 33) ? 700 : FULL, 0, 3'b000,
                32 * ((n - 32) / 12), (n - 32) % 12, 32, 8);
    short_lines(167);
    full_line("a_l212", FULL, 0, 3'b000, 480, 0, 32, 8);
    short_lines(10);
    full_line("a_l223", FULL, 0, 3'b000, 480, 11, 32, 8);
    run_line(FULL, 0, 3'b000);
    chk("a_l224_vact", 32'(ln_vact), 0);
    chk("a_l224_nfetch", ln_nf, 0);

    // RG2 graphics frame
    ag = 1'b1; gm = 3'b011;
    fsync();
    short_lines(31);
    full_line("g_l32", FULL, 0, 3'b011, 0, 0, 16, 16);
    full_line("g_l33", FULL, 0, 3'b011, 0, 1, 16, 16);
    full_line("g_l34", FULL, 0, 3'b011, 16, 0, 16, 16);
    short_lines(188);
    full_line("g_l223", FULL, 0, 3'b011, 1520, 1, 16, 16);

    // fsn arriving mid active line, switching to format=1
    ag = 1'b0; gm = 3'b000; format = 1'b0;
    fsync();
    short_lines(31);
    full_line("f_l32", FULL, 0, 3'b000, 0, 0, 32, 8);
    hsn = 1'b0;
    tick();
    tick();
    hsn = 1'b1;
    repeat (100) tick();
    chk("f_da_pre", 32'(da), 8);
    chk("f_row_line_pre", 32'(row_line), 1);
    format = 1'b1;
    fsn = 1'b0;
    tick();
    tick();
    fsn = 1'b1;
    tick();
    chk("f_da", 32'(da), 0);
    chk("f_row_line", 32'(row_line), 0);
    chk("f_vact_hold", 32'(vactive), 1);
    repeat (220) tick();
    run_line(FULL, 0, 3'b000);
    chk("f_l1_vact", 32'(ln_vact), 0);
    chk("f_l1_nfetch", ln_nf, 0);
    short_lines(56);
    chk("f_l57_vact", 32'(ln_vact), 0);
    full_line("f_l58", FULL, 0, 3'b000, 0, 0, 32, 8);

    // gm change mid-line: spacing holds until the next hsn rise,
    // and the drop to 2 lines per row ends the row early
    ag = 1'b1; gm = 3'b010;
    full_line("m_l59", FULL, 100, 3'b011, 0, 1, 32, 8);
    full_line("m_l60", FULL, 0, 3'b011, 0, 2, 16, 16);
    full_line("m_l61", FULL, 0, 3'b011, 16, 0, 16, 16);

    // hsn and fsn rising together: frame start wins, vc restarts at 0
    format = 1'b0;
    hsn = 1'b0; fsn = 1'b0;
    tick();
    tick();
    hsn = 1'b1; fsn = 1'b1;
    tick();
    chk("s_da", 32'(da), 0);
    chk("s_row_line", 32'(row_line), 0);
    chk("s_vact", 32'(vactive), 0);
    short_lines(31);
    chk("s_l31_vact", 32'(ln_vact), 0);
    full_line("s_l32", FULL, 0, 3'b011, 0, 0, 16, 16);

    // Reset in the middle of an active line
    hsn = 1'b0;
    tick();
    tick();
    hsn = 1'b1;
    repeat (60) tick();
    chk("r_da_pre", 32'(da), 2);
    chk("r_row_line_pre", 32'(row_line), 1);
    chk("r_de_pre", 32'(de), 1);
    reset_n = 1'b0;
    tick();
    chk("r_da", 32'(da), 0);
    chk("r_de", 32'(de), 0);
    chk("r_fetch", 32'(fetch), 0);
    chk("r_row_line", 32'(row_line), 0);
    chk("r_hactive", 32'(hactive), 0);
    chk("r_vactive", 32'(vactive), 0);
    reset_n = 1'b1;
    repeat (3) tick();
    chk("r_de_after", 32'(de), 0);

    chk("extra_fetches", extra_fetches, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/video_address_gen.md
Name: video_address_gen

Overview:
- Downstream consumer of the frame timing stage.
- Takes the active-low hsn/fsn sync outputs and the mode inputs, and tracks horizontal and vertical position relative to sync end.
- Generates the active-display window, byte-fetch strobes, the 13-bit display address (DA) into video RAM, and the character-row line counter.
- Feeds the pixel/character serialiser and the RAM interface.

Parameters:
- H_START, 38: pixel clocks from hsn rising edge to first active pixel.
- ACTIVE_W, 256: active pixels per line.
- V_START0, 32: lines from fsn rising edge to first active line, format=0.
- V_START1, 58: lines from fsn rising edge to first active line, format=1.
- ACTIVE_H, 192: active lines per frame.
- CHAR_LINES, 12: lines per alphanumeric character row.

Ports:
- clk, input, 1: pixel clock, same clock as the frame timing stage.
- reset_n, input, 1: synchronous, active-low reset.
- hsn, input, 1: horizontal sync, low during sync.
- fsn, input, 1: field sync, low during sync.
- format, input, 1: selects V_START0 (0) or V_START1 (1).
- ag, input, 1: 0 = alphanumeric/semigraphic, 1 = full graphics.
- gm, input, 3: graphics mode CG1..RG6 (000..111).
- da, output, 13: display RAM address.
- fetch, output, 1: one-cycle strobe; RAM byte at da is to be latched this cycle.
- row_line, output, 4: line within current character/graphics row.
- hactive, output, 1: horizontal active window.
- vactive, output, 1: vertical active window.
- de, output, 1: hactive & vactive.

Behaviour:
- Reset (reset_n low at a clk edge): da=0, fetch=0, row_line=0, hactive=0, vactive=0, de=0. Internal counters zero; sync edge registers are loaded with 1. Reset mid-line aborts all state; normal operation resumes from the next hsn/fsn rising edges.
- Edge detect: hsn and fsn are registered once. A rise is prev==0 && cur==1, and is acted on in the cycle after the input rises.
- Horizontal counter hc (9 bits):
  - Cleared to 0 on hsn rise, otherwise increments.
  - Saturates at 511; it never wraps.
  - hactive=1 when H_START <= hc < H_START+ACTIVE_W. Registered, so 1-cycle latency from hc.
- Vertical counter vc (9 bits):
  - Cleared on fsn rise.
  - Incremented on hsn rise; saturates at 511.
  - vstart = format ? V_START1 : V_START0, sampled at fsn rise.
  - vactive=1 when vstart <= vc < vstart+ACTIVE_H.
  - Updated at hsn rise only, so it never changes mid-line.
- Mode latch: ag/gm are sampled at each hsn rise and held for the whole line.
- Row geometry:
  - bytes per row (BPR): ag=0 gives 32.
  - ag=1 gives BPR by gm: 000:16, 001:16, 010:32, 011:16, 100:32, 101:16, 110:32, 111:32.
  - lines per row (LPR): ag=0 gives CHAR_LINES.
  - ag=1 gives LPR by gm: 000:3, 001:3, 010:3, 011:2, 100:2, 101:1, 110:1, 111:1.
- Fetch:
  - While hactive & vactive, fetch pulses on the first active cycle and then every 8 pixels (BPR=32) or every 16 pixels (BPR=16).
  - da increments by 1 the cycle after each fetch; it is 13-bit and wraps 8191->0.
  - Outside de, fetch=0 and da holds.
- Row bookkeeping: row_start (13 bits) is held internally.
  - First active line: row_start=0, row_line=0.
  - At each hsn rise ending an active line: if row_line==LPR-1, set row_line=0 and row_start=row_start+BPR; else row_line+1, and row_start is unchanged.
  - da is then loaded with the updated row_start.
  - If a mode change lowers LPR below row_line+1, the row ends at the next hsn rise.
- Frame: at fsn rise, da=0, row_start=0, row_line=0.
- Simultaneous hsn and fsn rise in one cycle: frame actions win, then vc=0.
- Missing hsn: hc saturates at 511, hactive stays 0, and no fetches occur.

Decomposition:
- Shared package vdg_pkg holds:
  - gm encodings (CG1..RG6) as constants.
  - BPR/LPR lookup functions.
  - DA_W=13 and CHAR_LINES.
- One natural sub-module: sync_edge, the register plus rise detector, instantiated for hsn and fsn.

Test Plan:
- Reset: hold reset_n=0 for 5 clk with the sync inputs toggling -> da=0, fetch=0, de=0, row_line=0 throughout.
- Horizontal timing, ag=0, active line: hsn rise -> first fetch 1+H_START cycles later with da=row_start. 32 fetches 8 clk apart, da ends at row_start+32, hactive high for exactly 256 clk.
- Alpha rows, format=0: full frame -> vactive starts at line 32 and lasts 192 lines. da repeats 0..31 for 12 lines, then 32..63, and so on. Final row starts at da=480, row_line cycles 0..11.
- Graphics RG2, gm=011: full frame -> 16 fetches/line 16 clk apart, each row repeated 2 lines. Last line starts at da=1520, last fetch at da=1535.
- format=1 with fsn arriving mid active line -> da=0, row_line=0 on the next cycle, vactive deasserts at the following hsn rise, and the first active line is 58.
- hsn and fsn rising in the same cycle, plus gm change mid-line -> frame reset takes priority. The gm change takes effect only at the next hsn rise, with no fetch-spacing change within the line.
